// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide arbiter.
// The typedefs are sized from the MD_* constants; change those to resize the block.
package muldiv_pkg;

  localparam int MD_XLEN       = 32;
  localparam int MD_NUM_STAGE  = 2;
  localparam int MD_NUM_REQ    = 2;
  localparam int MD_RESP_DEPTH = 4;
  localparam int MD_IDW        = (MD_NUM_REQ > 1) ? $clog2(MD_NUM_REQ) : 1;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef struct packed {
    logic              live;
    logic [MD_IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [MD_IDW-1:0]  id;
    logic [MD_XLEN-1:0] data;
  } resp_t;

endpackage

// File: rtl/muldiv_resp_fifo.sv
// Response FIFO with per-entry valid bits; killed entries are skipped at the
// read side one per cycle, so their slots stay counted until skipped.
module muldiv_resp_fifo
  import muldiv_pkg::*;
#(
  parameter int  DEPTH   = MD_RESP_DEPTH,
  parameter int  NUM_REQ = MD_NUM_REQ,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_push,
  input  resp_t              i_push_data,
  input  logic               i_pop,
  input  logic [NUM_REQ-1:0] i_kill,
  output logic               o_head_valid,
  output resp_t              o_head,
  output logic [CW-1:0]      o_count
);

  resp_t            r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  logic w_nonempty;
  logic w_head_kill;
  logic w_adv;

  assign w_nonempty   = (r_count != '0);
  assign w_head_kill  = i_kill[r_mem[r_rd].id];
  assign o_head_valid = w_nonempty && r_vld[r_rd] && !w_head_kill;
  assign o_head       = r_mem[r_rd];
  assign o_count      = r_count;
  // Advance on a real pop, or drop an invalidated head without output.
  assign w_adv        = w_nonempty && (!r_vld[r_rd] || i_pop);

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr] <= i_push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && i_kill[r_mem[i].id]) r_vld[i] <= 1'b0;
      end
      if (w_adv) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + PW'(1);
      end
      if (i_push) begin
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_adv);
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one pipelined mul/div unit between requesters,
// with a fixed-latency tag pipe and a credit-gated response FIFO.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int  XLEN       = MD_XLEN,
  parameter int  NUM_STAGE  = MD_NUM_STAGE,
  parameter int  NUM_REQ    = MD_NUM_REQ,
  parameter int  RESP_DEPTH = MD_RESP_DEPTH,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LAT        = NUM_STAGE - 1,
  localparam int CW         = $clog2(RESP_DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_op1_i,
  input  logic [NUM_REQ*XLEN-1:0] req_op2_i,
  input  logic [NUM_REQ*3-1:0]    req_funct3_i,
  input  logic [NUM_REQ-1:0]      kill_i,
  output logic [XLEN-1:0]         md_in1_o,
  output logic [XLEN-1:0]         md_in2_o,
  output logic [6:0]              md_opcode_o,
  output logic [6:0]              md_funct7_o,
  output logic [2:0]              md_funct3_o,
  input  logic [XLEN-1:0]         md_result_i,
  input  logic                    md_valid_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IDW-1:0]          resp_id_o,
  output logic [XLEN-1:0]         resp_data_o,
  output logic                    busy_o,
  output logic                    err_o
);

  // r_run holds off grants during reset and its release cycle, keeping
  // every output at 0 while rst_ni is low without a combinational reset path.
  logic           r_run;
  logic [IDW-1:0] r_rr;
  tag_t           r_tag [LAT];
  logic [LAT-1:0] r_occ;
  logic           r_err;

  tag_t           w_tag_n [LAT];
  logic [LAT-1:0] w_occ_n;
  logic [CW-1:0]  w_inflight;
  logic [CW-1:0]  w_fifo_count;
  logic           w_credit;
  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_id;
  logic           w_head_live;
  logic           w_push;
  logic           w_pop;
  logic           w_err_set;
  logic           w_fifo_vld;
  resp_t          w_fifo_head;
  resp_t          w_push_data;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + CW'(r_tag[i].live);
  end

  assign w_credit = r_run && ((int'(w_inflight) + int'(w_fifo_count)) < RESP_DEPTH);

  always_comb begin
    int             t;
    logic [IDW-1:0] idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    t           = 0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = int'(r_rr) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      idx = IDW'(t);
      if (!w_grant_vld && w_credit && req_valid_i[idx] && !kill_i[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    md_in1_o    = '0;
    md_in2_o    = '0;
    md_opcode_o = '0;
    md_funct7_o = '0;
    md_funct3_o = '0;
    if (w_grant_vld) begin
      req_ready_o[w_grant_id] = 1'b1;
      md_in1_o    = req_op1_i[int'(w_grant_id)*XLEN +: XLEN];
      md_in2_o    = req_op2_i[int'(w_grant_id)*XLEN +: XLEN];
      md_funct3_o = req_funct3_i[int'(w_grant_id)*3 +: 3];
      md_opcode_o = OPCODE_R;
      md_funct7_o = FUNCT7_MULDIV;
    end
  end

  // occ marks a slot whose result the unit will still return, even if killed.
  always_comb begin
    w_tag_n[0] = '{live: w_grant_vld, id: w_grant_id};
    w_occ_n    = '0;
    w_occ_n[0] = w_grant_vld;
    for (int i = 1; i < LAT; i++) begin
      w_tag_n[i] = r_tag[i-1];
      w_occ_n[i] = r_occ[i-1];
    end
    for (int i = 0; i < LAT; i++) begin
      if (kill_i[w_tag_n[i].id]) w_tag_n[i].live = 1'b0;
    end
  end

  assign w_head_live = r_tag[LAT-1].live && !kill_i[r_tag[LAT-1].id];
  assign w_push      = w_head_live && md_valid_i;
  assign w_err_set   = (md_valid_i && !r_occ[LAT-1]) || (r_tag[LAT-1].live && !md_valid_i);
  assign w_push_data = '{id: r_tag[LAT-1].id, data: md_result_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run <= 1'b0;
      r_rr  <= '0;
      r_occ <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_grant_vld) begin
        r_rr <= (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + IDW'(1);
      end
      r_tag <= w_tag_n;
      r_occ <= w_occ_n;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  muldiv_resp_fifo #(
    .DEPTH   (RESP_DEPTH),
    .NUM_REQ (NUM_REQ)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_kill       (kill_i),
    .o_head_valid (w_fifo_vld),
    .o_head       (w_fifo_head),
    .o_count      (w_fifo_count)
  );

  assign w_pop        = w_fifo_vld && resp_ready_i;
  assign resp_valid_o = w_fifo_vld;
  assign resp_id_o    = w_fifo_vld ? w_fifo_head.id : '0;
  assign resp_data_o  = w_fifo_vld ? w_fifo_head.data : '0;
  assign busy_o       = (w_inflight != '0) || (w_fifo_count != '0);
  assign err_o        = r_err;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a one-cycle mul/div unit model.
module tb_muldiv_arbiter;
  import muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_op1_i;
  logic [63:0] req_op2_i;
  logic [5:0]  req_funct3_i;
  logic [1:0]  kill_i;
  logic [31:0] md_in1_o, md_in2_o;
  logic [6:0]  md_opcode_o, md_funct7_o;
  logic [2:0]  md_funct3_o;
  logic [31:0] md_result_i;
  logic        md_valid_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [0:0]  resp_id_o;
  logic [31:0] resp_data_o;
  logic        busy_o;
  logic        err_o;

  logic        r_mvld;
  logic [31:0] r_mres;
  logic        inj;
  int          total = 0;
  int          bad = 0;
  int          q_id[$];
  logic [31:0] q_data[$];
  logic [1:0]  exp_g[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  int          exp_id[4] = '{1, 0, 1, 0};
  logic [31:0] exp_d[4] = '{32'd2, 32'd14, 32'd2, 32'd14};

  always #5 clk_i = ~clk_i;

  muldiv_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_funct3_i(req_funct3_i),
    .kill_i(kill_i),
    .md_in1_o(md_in1_o), .md_in2_o(md_in2_o), .md_opcode_o(md_opcode_o),
    .md_funct7_o(md_funct7_o), .md_funct3_o(md_funct3_o),
    .md_result_i(md_result_i), .md_valid_i(md_valid_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  function automatic logic [31:0] unit_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      FUNCT3_MUL:    p = sa * sb;
      FUNCT3_MULH:   p = (sa * sb) >>> 32;
      FUNCT3_MULHSU: p = (sa * $signed(ua)) >>> 32;
      FUNCT3_MULHU:  p = $signed((ua * ub) >> 32);
      FUNCT3_DIV:    p = (b == 0) ? -64'sd1 : sa / sb;
      FUNCT3_DIVU:   p = (b == 0) ? -64'sd1 : $signed(ua / ub);
      FUNCT3_REM:    p = (b == 0) ? sa : sa % sb;
      default:       p = (b == 0) ? $signed(ua) : $signed(ua % ub);
    endcase
    return p[31:0];
  endfunction

  // Unit model: one-cycle latency, reset by the same rst_ni.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mvld <= 1'b0;
      r_mres <= '0;
    end else begin
      r_mvld <= (md_opcode_o == OPCODE_R) && (md_funct7_o == FUNCT7_MULDIV);
      r_mres <= unit_calc(md_in1_o, md_in2_o, md_funct3_o);
    end
  end
  assign md_valid_i  = r_mvld | inj;
  assign md_result_i = r_mres;

  always @(negedge clk_i) begin
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      q_id.push_back(int'(resp_id_o));
      q_data.push_back(resp_data_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = '0; req_op1_i = '0; req_op2_i = '0;
    req_funct3_i = '0; kill_i = '0; resp_ready_i = 1'b0; inj = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_opcode", md_opcode_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    cyc();

    // single MUL 7*6
    req_valid_i = 2'b01; req_op1_i = {32'd0, 32'd7}; req_op2_i = {32'd0, 32'd6};
    req_funct3_i = {3'b000, FUNCT3_MUL}; resp_ready_i = 1'b1;
    #1;
    chk("mul_grant", req_ready_o, 2'b01);
    chk("mul_opcode", md_opcode_o, OPCODE_R);
    chk("mul_funct7", md_funct7_o, FUNCT7_MULDIV);
    chk("mul_in1", md_in1_o, 7);
    chk("mul_in2", md_in2_o, 6);
    cyc();
    req_valid_i = 2'b00;
    #1;
    chk("mul_md_valid", md_valid_i, 1);
    chk("mul_busy_inflight", busy_o, 1);
    chk("mul_idle_opcode", md_opcode_o, 0);
    cyc();
    #1;
    chk("mul_resp_valid", resp_valid_o, 1);
    chk("mul_resp_id", resp_id_o, 0);
    chk("mul_resp_data", resp_data_o, 42);
    cyc();
    #1;
    chk("mul_busy_drop", busy_o, 0);
    chk("mul_resp_gone", resp_valid_o, 0);

    // round robin: pointer is 1 after the single grant to requester 0
    q_id.delete(); q_data.delete();
    req_op1_i = {32'd100, 32'd100}; req_op2_i = {32'd7, 32'd7};
    req_funct3_i = {FUNCT3_REMU, FUNCT3_DIVU}; req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", req_ready_o, exp_g[i]);
      cyc();
    end
    req_valid_i = 2'b00;
    repeat (4) cyc();
    chk("rr_resp_count", q_id.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_id.size()) begin
        chk("rr_resp_id", q_id[i], exp_id[i]);
        chk("rr_resp_data", q_data[i], exp_d[i]);
      end
    end
    chk("rr_busy_end", busy_o, 0);

    // backpressure: credit of 4, then one pop buys one more grant
    q_id.delete(); q_data.delete();
    resp_ready_i = 1'b0; req_valid_i = 2'b01;
    req_op1_i = {32'd0, 32'd3}; req_op2_i = {32'd0, 32'd5}; req_funct3_i = 6'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("bp_grant", req_ready_o, (i < 4) ? 2'b01 : 2'b00);
      cyc();
    end
    chk("bp_resp_valid", resp_valid_o, 1);
    chk("bp_resp_data", resp_data_o, 15);
    resp_ready_i = 1'b1;
    #1;
    chk("bp_no_same_cycle_credit", req_ready_o, 2'b00);
    cyc();
    resp_ready_i = 1'b0;
    #1;
    chk("bp_grant_after_pop", req_ready_o, 2'b01);
    cyc();
    #1;
    chk("bp_full_again", req_ready_o, 2'b00);
    req_valid_i = 2'b00;
    cyc();
    resp_ready_i = 1'b1;
    repeat (6) cyc();
    chk("bp_resp_count", q_id.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < q_id.size()) begin
        chk("bp_resp_id", q_id[i], 0);
        chk("bp_resp_data", q_data[i], 15);
      end
    end
    chk("bp_busy_end", busy_o, 0);

    // kill: req1 DIV issued, killed next cycle; req0 MULHU survives
    q_id.delete(); q_data.delete();
    req_op1_i = {32'hFFFF_FFF8, 32'hFFFF_FFFF}; req_op2_i = {32'd2, 32'd2};
    req_funct3_i = {FUNCT3_DIV, FUNCT3_MULHU}; req_valid_i = 2'b11;
    #1;
    chk("kill_grant1", req_ready_o, 2'b10);
    cyc();
    req_valid_i = 2'b01; kill_i = 2'b10;
    #1;
    chk("kill_grant0", req_ready_o, 2'b01);
    cyc();
    kill_i = 2'b00; req_valid_i = 2'b00;
    repeat (4) cyc();
    chk("kill_resp_count", q_id.size(), 1);
    if (q_id.size() > 0) begin
      chk("kill_resp_id", q_id[0], 0);
      chk("kill_resp_data", q_data[0], 32'h0000_0001);
    end
    chk("kill_no_err", err_o, 0);
    chk("kill_busy_end", busy_o, 0);

    // spurious md_valid with an empty tag pipe
    q_id.delete(); q_data.delete();
    inj = 1'b1;
    cyc();
    inj = 1'b0;
    #1;
    chk("err_set", err_o, 1);
    chk("err_no_resp", resp_valid_o, 0);
    chk("err_no_busy", busy_o, 0);
    repeat (3) cyc();
    chk("err_sticky", err_o, 1);
    chk("err_fifo_untouched", q_id.size(), 0);

    // reset with three ops in flight
    resp_ready_i = 1'b0;
    req_op1_i = {32'd7, 32'd7}; req_op2_i = {32'd6, 32'd6}; req_funct3_i = 6'd0;
    req_valid_i = 2'b11;
    repeat (3) cyc();
    chk("rstmid_busy_before", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rstmid_ready", req_ready_o, 0);
    chk("rstmid_resp_valid", resp_valid_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_err", err_o, 0);
    chk("rstmid_opcode", md_opcode_o, 0);
    chk("rstmid_in1", md_in1_o, 0);
    req_valid_i = 2'b00;
    cyc();
    rst_ni = 1'b1; resp_ready_i = 1'b1;
    repeat (5) cyc();
    chk("rstmid_no_resp", q_id.size(), 0);
    chk("rstmid_busy_after", busy_o, 0);
    chk("rstmid_err_after", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
